// File: rtl/spi_master_multimode.sv
// SPI master: one transfer at a time, run-time CPOL/CPHA, selectable chip enable, start/busy/done handshake.
// Latency: done pulses 1 + (2*DATA_W+1)*CLK_DIV cycles after the accept edge; requests are ignored while busy.
module spi_master_multimode #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 2,
    parameter int NUM_CS    = 2,
    parameter int LSB_FIRST = 0,
    localparam int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SPI_start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              SPI_MISO,
    output logic              SPI_MOSI,
    output logic              SPI_CLK,
    output logic [NUM_CS-1:0] SPI_EN,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] data_out
);

    localparam int CNT_W = $clog2(2 * DATA_W + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_W);
    localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [CNT_W-1:0]    edge_q, edge_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [NUM_CS-1:0]   en_q, en_d;
    logic                mosi_q, mosi_d;
    logic                sclk_q, sclk_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic                done_q, done_d;

    logic                tick;
    logic                cs_ok;
    logic                tx_bit;
    logic                first_bit;
    logic                leading;
    logic [CNT_W-1:0]    next_edge;
    logic [DATA_W-1:0]   tx_shift;
    logic [DATA_W-1:0]   first_shift;
    logic [DATA_W-1:0]   rx_shift;

    // Bit-order helpers: the same order is used to shift out and to assemble received bits.
    always_comb begin
        if (LSB_FIRST != 0) begin
            tx_bit      = tx_q[0];
            tx_shift    = {1'b0, tx_q[DATA_W-1:1]};
            first_bit   = data_in[0];
            first_shift = {1'b0, data_in[DATA_W-1:1]};
            rx_shift    = {SPI_MISO, rx_q[DATA_W-1:1]};
        end else begin
            tx_bit      = tx_q[DATA_W-1];
            tx_shift    = {tx_q[DATA_W-2:0], 1'b0};
            first_bit   = data_in[DATA_W-1];
            first_shift = {data_in[DATA_W-2:0], 1'b0};
            rx_shift    = {rx_q[DATA_W-2:0], SPI_MISO};
        end
    end

    assign tick      = (div_q == DIV_MAX);
    assign cs_ok     = (int'(cs_sel) < NUM_CS);
    assign next_edge = edge_q + CNT_W'(1);
    assign leading   = next_edge[0];

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        edge_d  = edge_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        en_d    = en_q;
        mosi_d  = mosi_q;
        sclk_d  = sclk_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                div_d  = '0;
                edge_d = '0;
                // done_q marks the last busy cycle; the next request is taken one cycle later.
                if (SPI_start && !done_q && cs_ok) begin
                    state_d = SETUP;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    sclk_d  = cpol;
                    en_d    = NUM_CS'(1) << cs_sel;
                    rx_d    = '0;
                    if (cpha) begin
                        tx_d   = data_in;
                        mosi_d = 1'b0;
                    end else begin
                        tx_d   = first_shift;
                        mosi_d = first_bit;
                    end
                end
            end
            SETUP, XFER: begin
                div_d = tick ? '0 : div_q + DIV_W'(1);
                if (tick) begin
                    sclk_d = ~sclk_q;
                    edge_d = next_edge;
                    // Drive edges are leading for cpha=1 and trailing for cpha=0; the other edges sample.
                    if (leading == cpha_q) begin
                        if (next_edge != LAST_EDGE) begin
                            mosi_d = tx_bit;
                            tx_d   = tx_shift;
                        end
                    end else begin
                        rx_d = rx_shift;
                    end
                    state_d = (next_edge == LAST_EDGE) ? HOLD : XFER;
                end
            end
            HOLD: begin
                div_d = tick ? '0 : div_q + DIV_W'(1);
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    dout_d  = rx_q;
                    en_d    = '0;
                    mosi_d  = 1'b0;
                    div_d   = '0;
                    edge_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            edge_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            en_q    <= '0;
            mosi_q  <= 1'b0;
            sclk_q  <= 1'b0;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            edge_q  <= edge_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            en_q    <= en_d;
            mosi_q  <= mosi_d;
            sclk_q  <= sclk_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            done_q  <= done_d;
        end
    end

    assign SPI_MOSI = mosi_q;
    assign SPI_CLK  = sclk_q;
    assign SPI_EN   = en_q;
    assign done     = done_q;
    assign data_out = dout_q;
    assign busy     = (state_q != IDLE) | done_q;

endmodule

// File: tb/tb_spi_master_multimode.sv
// Bench for spi_master_multimode: 8-bit MSB-first instance with an SPI slave model,
// plus a 16-bit LSB-first, three-chip-select instance in loopback.
module tb_spi_master_multimode;

    localparam int DW     = 8;
    localparam int CD     = 2;
    localparam int DONE_C = 1 + (2 * DW + 1) * CD;
    localparam int DONE_B = 1 + (2 * 16 + 1) * 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: DATA_W=8, CLK_DIV=2, NUM_CS=2, MSB first
    logic       a_start, a_cpol, a_cpha, a_cs, a_miso, a_mosi, a_sclk, a_busy, a_done;
    logic [7:0] a_din, a_dout;
    logic [1:0] a_en;
    logic       loop_en;
    logic       slave_miso;
    assign a_miso = loop_en ? a_mosi : slave_miso;

    spi_master_multimode #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(2), .LSB_FIRST(0)) dut (
        .clk(clk), .rst_n(rst_n), .SPI_start(a_start), .data_in(a_din), .cpol(a_cpol),
        .cpha(a_cpha), .cs_sel(a_cs), .SPI_MISO(a_miso), .SPI_MOSI(a_mosi), .SPI_CLK(a_sclk),
        .SPI_EN(a_en), .busy(a_busy), .done(a_done), .data_out(a_dout));

    // Instance B: DATA_W=16, CLK_DIV=1, NUM_CS=3, LSB first, MOSI looped to MISO
    logic        b_start, b_cpol, b_cpha, b_mosi, b_sclk, b_busy, b_done;
    logic [1:0]  b_cs;
    logic [2:0]  b_en;
    logic [15:0] b_din, b_dout;

    spi_master_multimode #(.DATA_W(16), .CLK_DIV(1), .NUM_CS(3), .LSB_FIRST(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .SPI_start(b_start), .data_in(b_din), .cpol(b_cpol),
        .cpha(b_cpha), .cs_sel(b_cs), .SPI_MISO(b_mosi), .SPI_MOSI(b_mosi), .SPI_CLK(b_sclk),
        .SPI_EN(b_en), .busy(b_busy), .done(b_done), .data_out(b_dout));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Slave for instance A: MSB first, mode taken from sl_cpol/sl_cpha, re-armed by toggling sl_arm.
    logic [7:0] sl_tx;
    logic [7:0] sl_rx;
    logic       sl_cpol, sl_cpha;
    logic       sl_arm;
    logic       sl_arm_seen = 1'b0;
    int         sl_lead, sl_in, sl_out;

    always @(a_sclk or sl_arm) begin
        if (sl_arm !== sl_arm_seen) begin
            sl_arm_seen = sl_arm;
            sl_rx   = '0;
            sl_lead = 0;
            sl_in   = 0;
            sl_out  = 0;
            slave_miso = 1'b0;
            if (!sl_cpha) begin
                slave_miso = sl_tx[DW-1];
                sl_out = 1;
            end
        end else if (|a_en) begin
            if (a_sclk !== sl_cpol) begin
                sl_lead++;
                if (!sl_cpha) begin
                    if (sl_in < DW) sl_rx[DW-1-sl_in] = a_mosi;
                    sl_in++;
                end else begin
                    if (sl_out < DW) slave_miso = sl_tx[DW-1-sl_out];
                    sl_out++;
                end
            end else if (sl_lead > 0) begin
                if (!sl_cpha) begin
                    if (sl_out < DW) slave_miso = sl_tx[DW-1-sl_out];
                    sl_out++;
                end else begin
                    if (sl_in < DW) sl_rx[DW-1-sl_in] = a_mosi;
                    sl_in++;
                end
            end
        end
    end

    // Instance B MOSI bits as seen on each rising (leading, mode 0) SCLK edge.
    logic bq[$];
    always @(posedge b_sclk) if (|b_en) bq.push_back(b_mosi);

    typedef struct {
        logic [7:0] d;
        logic       pol, pha, cs;
        logic [7:0] sw;
        logic       lp;
        logic [7:0] exp_dout;
        logic [7:0] exp_srx;
        logic [1:0] exp_en;
    } vec_t;

    // Reference: the slave always receives the transmit word; the master receives
    // either its own word (loopback) or the slave's word; exactly the selected enable is set.
    function automatic vec_t model(input logic [7:0] d, input logic pol, input logic pha,
                                   input logic cs, input logic [7:0] sw, input logic lp);
        vec_t v;
        v.d = d; v.pol = pol; v.pha = pha; v.cs = cs; v.sw = sw; v.lp = lp;
        v.exp_dout = lp ? d : sw;
        v.exp_srx  = d;
        v.exp_en   = (cs == 1'b1) ? 2'b10 : 2'b01;
        return v;
    endfunction

    task automatic arm_slave(input logic [7:0] sw, input logic pol, input logic pha);
        sl_tx   = sw;
        sl_cpol = pol;
        sl_cpha = pha;
        sl_arm  = ~sl_arm;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int c;
        int frame_bad;
        int hold_bad;
        bit seen;
        logic [7:0] prev;
        @(negedge clk);
        arm_slave(v.sw, v.pol, v.pha);
        loop_en = v.lp;
        a_din = v.d; a_cpol = v.pol; a_cpha = v.pha; a_cs = v.cs; a_start = 1'b1;
        prev = a_dout;
        @(posedge clk);
        @(negedge clk);
        a_start = 1'b0; a_din = ~v.d; a_cpol = ~v.pol; a_cpha = ~v.pha; a_cs = ~v.cs;
        check({tag, "_setup_en"}, a_en, v.exp_en);
        check({tag, "_setup_clk"}, a_sclk, v.pol);
        c = 1; seen = 0; frame_bad = 0; hold_bad = 0;
        while (c < 80 && !seen) begin
            if (a_done) seen = 1;
            else begin
                if (a_en !== v.exp_en || a_busy !== 1'b1) frame_bad++;
                if (a_dout !== prev) hold_bad++;
                @(negedge clk);
                c++;
            end
        end
        check({tag, "_done_cycle"}, c, DONE_C);
        check({tag, "_done_en"}, a_en, 2'b00);
        check({tag, "_done_mosi"}, a_mosi, 1'b0);
        check({tag, "_done_busy"}, a_busy, 1'b1);
        check({tag, "_dout"}, a_dout, v.exp_dout);
        check({tag, "_slave_rx"}, sl_rx, v.exp_srx);
        check({tag, "_lead_edges"}, sl_lead, DW);
        check({tag, "_frame"}, frame_bad, 0);
        check({tag, "_dout_hold"}, hold_bad, 0);
        @(negedge clk);
        check({tag, "_after_busy"}, a_busy, 1'b0);
        check({tag, "_after_done"}, a_done, 1'b0);
        check({tag, "_idle_clk"}, a_sclk, v.pol);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        vec_t v;
        int   dones, accepts, gap, busy_gap, en_low, busy_low, bad, c, base, mid_ones;
        logic prev_busy;

        tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'hA5, 8'hA5, 2'b10};
        tbl[1] = '{8'hC3, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 8'h3C, 8'hC3, 2'b01};
        tbl[2] = '{8'hC3, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h3C, 8'hC3, 2'b10};
        tbl[3] = '{8'hC3, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 8'h3C, 8'hC3, 2'b01};
        tbl[4] = '{8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 8'h80, 8'h01, 2'b01};
        tbl[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 8'hFF, 2'b10};

        rst_n = 1'b0; sl_arm = 1'b0; loop_en = 1'b0;
        a_start = 1'b0; a_din = '0; a_cpol = 1'b0; a_cpha = 1'b0; a_cs = 1'b0;
        b_start = 1'b0; b_din = '0; b_cpol = 1'b0; b_cpha = 1'b0; b_cs = '0;
        repeat (3) @(negedge clk);
        check("rst_clk", a_sclk, 1'b0);
        check("rst_mosi", a_mosi, 1'b0);
        check("rst_en", a_en, 2'b00);
        check("rst_busy", a_busy, 1'b0);
        check("rst_done", a_done, 1'b0);
        check("rst_dout", a_dout, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 8; i++) begin
            v = model(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      8'($urandom), 1'($urandom));
            run_vec(v, $sformatf("rnd%0d", i));
        end

        // Asynchronous reset in the middle of a cpol=1 transfer.
        @(negedge clk);
        arm_slave(8'h00, 1'b1, 1'b0);
        loop_en = 1'b1;
        a_din = 8'h5A; a_cpol = 1'b1; a_cpha = 1'b0; a_cs = 1'b1; a_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_clk", a_sclk, 1'b0);
        check("arst_mosi", a_mosi, 1'b0);
        check("arst_en", a_en, 2'b00);
        check("arst_busy", a_busy, 1'b0);
        check("arst_done", a_done, 1'b0);
        check("arst_dout", a_dout, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (a_done || a_busy || a_en != 2'b00) bad++;
        end
        check("arst_quiet", bad, 0);

        // Back-to-back with SPI_start held high; data_in changes during the first transfer.
        @(negedge clk);
        arm_slave(8'h00, 1'b0, 1'b0);
        loop_en = 1'b1;
        a_din = 8'h96; a_cpol = 1'b0; a_cpha = 1'b0; a_cs = 1'b0; a_start = 1'b1;
        dones = 0; accepts = 0; gap = -1; busy_gap = -1; en_low = 0; busy_low = 0;
        prev_busy = a_busy;
        repeat (120) begin
            @(negedge clk);
            if (a_busy && !prev_busy) begin
                accepts++;
                if (accepts == 1) a_din = 8'h3B;
                else begin
                    a_start = 1'b0;
                    busy_gap = busy_low;
                end
            end
            if (a_done) begin
                dones++;
                check($sformatf("b2b_dout%0d", dones), a_dout, (dones == 1) ? 8'h96 : 8'h3B);
            end
            if (a_en == 2'b00) en_low++;
            else begin
                if (dones == 1 && gap < 0) gap = en_low;
                en_low = 0;
            end
            busy_low  = a_busy ? 0 : busy_low + 1;
            prev_busy = a_busy;
        end
        a_start = 1'b0;
        check("b2b_dones", dones, 2);
        check("b2b_accepts", accepts, 2);
        check("b2b_en_gap", (gap >= 1), 1'b1);
        check("b2b_busy_gap", busy_gap, 1);

        // Instance B: LSB first, 16 bits, cs_sel=2 of three enables.
        @(negedge clk);
        base = bq.size();
        b_din = 16'h8001; b_cs = 2'd2; b_cpol = 1'b0; b_cpha = 1'b0; b_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_start = 1'b0; b_din = 16'h0000; b_cs = 2'd0;
        check("b_setup_en", b_en, 3'b100);
        check("b_setup_mosi", b_mosi, 1'b1);
        c = 1;
        while (c < 80 && !b_done) begin
            @(negedge clk);
            c++;
        end
        check("b_done_cycle", c, DONE_B);
        check("b_bits", bq.size() - base, 16);
        mid_ones = -1;
        if (bq.size() >= base + 16) begin
            check("b_first_bit", bq[base], 1'b1);
            check("b_last_bit", bq[base + 15], 1'b1);
            mid_ones = 0;
            for (int i = 1; i < 15; i++) if (bq[base + i]) mid_ones++;
        end
        check("b_mid_bits", mid_ones, 0);
        check("b_dout", b_dout, 16'h8001);
        @(negedge clk);
        check("b_after_busy", b_busy, 1'b0);

        // Out-of-range chip select is ignored.
        b_din = 16'hFFFF; b_cs = 2'd3; b_start = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (b_busy || b_done || b_en != 3'b000) bad++;
        end
        b_start = 1'b0;
        check("b_reject", bad, 0);
        check("b_reject_dout", b_dout, 16'h8001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
